mem_wb_skid: RTL and testbench
==============================

# mem_wb_skid

Parametrised MEM/WB pipeline register with a ready/valid handshake, an optional one-entry skid buffer, synchronous flush and write-back selection. It sits between the memory stage and the register-file write port. It lets the write-back side stall without a combinational ready path back into the memory stage, and it inserts bubbles on flush. Payload fields are the ALU result, the memory read data, the destination register number and the two write-back control bits.

## Interface
- DATA_W, 32, width of result, read-data and write-data paths
- REG_ADDR_W, 5, width of destination register number
- SKID, 1, 1 = two-entry (main + skid) registered-ready mode; 0 = single-entry mode with combinational inReady
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries and of any same-cycle input
- inValid  in  1  upstream entry valid
- inReady  out  1  block can accept an entry this cycle
- inResult  in  DATA_W  ALU result
- inReadData  in  DATA_W  memory read data
- inRd  in  REG_ADDR_W  destination register
- inMemToReg  in  1  1 = write back read data, 0 = result
- inRegWrite  in  1  entry writes the register file
- outValid  out  1  head entry valid
- outReady  in  1  write-back side consumes head this cycle
- outResult, outReadData  out  DATA_W  head payload
- outRd  out  REG_ADDR_W  head destination
- outMemToReg, outRegWrite  out  1  head control bits
- outWriteData  out  DATA_W  outMemToReg ? outReadData : outResult (combinational from head)
- outWriteEnable  out  1  outValid & outRegWrite & (outRd != 0)
- occupancy  out  2  number of valid entries (0..2)

## Operation
- Accept = inValid & inReady; consume = outValid & outReady.
- SKID=1 states: EMPTY, ONE (main valid), FULL (main + skid valid). inReady = !skidValid, driven from a flop.
  - EMPTY: accept -> ONE, main <= input.
  - ONE: accept & consume -> ONE, main <= input. Accept & !consume -> FULL, skid <= input. Consume & !accept -> EMPTY. Otherwise hold.
  - FULL: inReady = 0. Consume -> ONE, main <= skid. Otherwise hold.
- SKID=0: main register only. inReady = !outValid | outReady. States are EMPTY and ONE with the same transitions; the FULL state does not exist.
- Order is strict FIFO. No entry is dropped or duplicated except by flush.
- flush has priority over every other event. All valid bits clear at the next edge, an accept in the same cycle is discarded, and a consume in the same cycle still counts downstream. Payload registers keep their values.
- Write to register 0 is suppressed through outWriteEnable; the entry still flows through and is consumed normally.
- While outValid & !outReady, all out* payload outputs are held stable.

## Timing
- Reset (asynchronous assert, synchronous release) clears all valid bits and zeroes all payload registers. Outputs during reset: outValid = 0, outWriteEnable = 0, occupancy = 0, all payload outputs 0, inReady = 1.
- Latency: an entry accepted at edge N is visible with outValid = 1 after edge N. There is no combinational in-to-out path.
- Throughput: 1 entry per cycle while outReady is held at 1.
- SKID=1: inReady falls the cycle after entering FULL and rises the cycle after leaving it. The block never depends combinationally on outReady for inReady.
- Reset mid-operation discards all entries immediately. The first accept after release is allowed on the first edge after reset deasserts.
- occupancy updates on the same edge as the state change.

## Test plan
- Reset: assert reset mid-stream with 2 entries held -> outValid = 0, occupancy = 0, inReady = 1, all payload 0 with no clock edge needed. After release, an entry with inResult = 0x1234 appears one cycle later.
- Streaming with SKID=1 and outReady = 1: 8 back-to-back entries with inRd = 1..8 -> outRd = 1..8 in order, one per cycle, inReady never drops.
- Backpressure: outReady = 0 while feeding entries with inResult = 0xA, 0xB, 0xC -> 0xA is held at the head, 0xB goes to skid, inReady = 0, 0xC is not accepted until outReady rises. Output order is then 0xA, 0xB, 0xC.
- Flush in FULL with a simultaneous inValid (inResult = 0xDEAD) -> next cycle outValid = 0, occupancy = 0, and 0xDEAD never appears.
- Write-back select: inMemToReg = 1, inReadData = 0x55, inResult = 0x66, inRd = 3, inRegWrite = 1 -> outWriteData = 0x55, outWriteEnable = 1. The same entry with inRd = 0 -> outWriteEnable = 0, outValid = 1.
- SKID=0 build: outReady = 0 with one entry held -> inReady = 0. Raising outReady with inValid = 1 in the same cycle -> the head is consumed and the new entry is loaded on the same edge, occupancy stays 1.

Source files
------------

// File: rtl/mem_wb_skid_if.sv
// Handshake and payload bundle between the memory stage, the MEM/WB register and write-back.
// An entry transfers on a rising edge where valid and ready are both high. Valid must not depend on ready.
interface mem_wb_skid_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  inValid;
   logic                  inReady;
   logic [DATA_W-1:0]     inResult;
   logic [DATA_W-1:0]     inReadData;
   logic [REG_ADDR_W-1:0] inRd;
   logic                  inMemToReg;
   logic                  inRegWrite;
   logic                  outValid;
   logic                  outReady;
   logic [DATA_W-1:0]     outResult;
   logic [DATA_W-1:0]     outReadData;
   logic [REG_ADDR_W-1:0] outRd;
   logic                  outMemToReg;
   logic                  outRegWrite;
   logic [DATA_W-1:0]     outWriteData;
   logic                  outWriteEnable;

   modport master (
      output inValid, inResult, inReadData, inRd, inMemToReg, inRegWrite, outReady,
      input  inReady, outValid, outResult, outReadData, outRd, outMemToReg, outRegWrite,
             outWriteData, outWriteEnable
   );

   modport slave (
      input  inValid, inResult, inReadData, inRd, inMemToReg, inRegWrite, outReady,
      output inReady, outValid, outResult, outReadData, outRd, outMemToReg, outRegWrite,
             outWriteData, outWriteEnable
   );
endinterface

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with optional one-entry skid buffer, flush and write-back select.
// SKID=1 gives a registered inReady; SKID=0 is a single register with combinational inReady.
module mem_wb_skid #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter bit SKID       = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   mem_wb_skid_if.slave bus,
   output logic [1:0]   occupancy,
   output logic [1:0]   state_dbg
);
   typedef struct packed {
      logic [DATA_W-1:0]     result;
      logic [DATA_W-1:0]     read_data;
      logic [REG_ADDR_W-1:0] rd;
      logic                  mem_to_reg;
      logic                  reg_write;
   } payload_t;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t   state_q, state_d;
   payload_t main_q, main_d;
   payload_t skid_q, skid_d;
   payload_t in_pl;
   logic     ready_q, ready_d;
   logic     out_valid;
   logic     in_ready;
   logic     accept;
   logic     consume;

   assign in_pl     = {bus.inResult, bus.inReadData, bus.inRd, bus.inMemToReg, bus.inRegWrite};
   assign out_valid = (state_q != EMPTY);
   assign in_ready  = SKID ? ready_q : (!out_valid || bus.outReady);
   assign accept    = bus.inValid && in_ready;
   assign consume   = out_valid && bus.outReady;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = in_pl;
            end
         end
         ONE: begin
            if (accept && consume) begin
               main_d = in_pl;
            end else if (accept && SKID) begin
               state_d = FULL;
               skid_d  = in_pl;
            end else if (consume) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (consume) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush only drops valid bits; payload registers keep whatever was loaded.
      if (flush) begin
         state_d = EMPTY;
      end
      ready_d = (state_d != FULL);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   assign bus.inReady        = in_ready;
   assign bus.outValid       = out_valid;
   assign bus.outResult      = main_q.result;
   assign bus.outReadData    = main_q.read_data;
   assign bus.outRd          = main_q.rd;
   assign bus.outMemToReg    = main_q.mem_to_reg;
   assign bus.outRegWrite    = main_q.reg_write;
   assign bus.outWriteData   = main_q.mem_to_reg ? main_q.read_data : main_q.result;
   assign bus.outWriteEnable = out_valid && main_q.reg_write && (main_q.rd != '0);
   assign occupancy          = state_q;
   assign state_dbg          = state_q;
endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: one SKID=1 and one SKID=0 instance, with an in-order
// expected queue for the SKID=1 instance and hand-computed spot values.
module tb_mem_wb_skid;
   logic clk;
   logic reset;
   logic flush1;
   logic flush0;
   logic [1:0] occ1, occ0;
   logic [1:0] st1, st0;

   int n_checks;
   int n_errors;
   logic [36:0] exp_q[$];

   mem_wb_skid_if #(.DATA_W(32), .REG_ADDR_W(5)) if1 ();
   mem_wb_skid_if #(.DATA_W(32), .REG_ADDR_W(5)) if0 ();

   mem_wb_skid #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1'b1)) u_skid1 (
      .clock     (clk),
      .reset     (reset),
      .flush     (flush1),
      .bus       (if1),
      .occupancy (occ1),
      .state_dbg (st1)
   );

   mem_wb_skid #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1'b0)) u_skid0 (
      .clock     (clk),
      .reset     (reset),
      .flush     (flush0),
      .bus       (if0),
      .occupancy (occ0),
      .state_dbg (st0)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [31:0] res, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic m2r, input logic rw);
      if1.inValid    = v;
      if1.inResult   = res;
      if1.inReadData = rdata;
      if1.inRd       = rd;
      if1.inMemToReg = m2r;
      if1.inRegWrite = rw;
   endtask

   // One clock for the SKID=1 instance: score the head on consume, record accepts, advance.
   task automatic tick();
      logic [36:0] exp;
      #1;
      if (if1.outValid && if1.outReady) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            exp = exp_q.pop_front();
            check("sb_rd", 32'(if1.outRd), 32'(exp[36:32]));
            check("sb_result", if1.outResult, exp[31:0]);
         end
      end
      if (flush1) exp_q.delete();
      else if (if1.inValid && if1.inReady) exp_q.push_back({if1.inRd, if1.inResult});
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset  = 1'b1;
      flush1 = 1'b0;
      flush0 = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      if1.outReady   = 1'b0;
      if0.inValid    = 1'b0;
      if0.inResult   = 32'h0;
      if0.inReadData = 32'h0;
      if0.inRd       = 5'd1;
      if0.inMemToReg = 1'b0;
      if0.inRegWrite = 1'b1;
      if0.outReady   = 1'b0;

      // Reset state
      #2;
      check("rst_valid", 32'(if1.outValid), 32'd0);
      check("rst_occ", 32'(occ1), 32'd0);
      check("rst_ready", 32'(if1.inReady), 32'd1);
      check("rst_result", if1.outResult, 32'h0);
      check("rst_we", 32'(if1.outWriteEnable), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Streaming, 8 back-to-back entries
      if1.outReady = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         set_in(1'b1, 32'h100 + 32'(i), 32'h0, 5'(i), 1'b0, 1'b1);
         tick();
         check("stream_ready", 32'(if1.inReady), 32'd1);
         check("stream_rd", 32'(if1.outRd), 32'(i));
      end
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      tick();
      check("stream_drain_occ", 32'(occ1), 32'd0);

      // Backpressure into the skid entry
      if1.outReady = 1'b0;
      set_in(1'b1, 32'hA, 32'h0, 5'd10, 1'b0, 1'b1);
      tick();
      check("bp_one_occ", 32'(occ1), 32'd1);
      check("bp_one_ready", 32'(if1.inReady), 32'd1);
      set_in(1'b1, 32'hB, 32'h0, 5'd11, 1'b0, 1'b1);
      tick();
      check("bp_full_occ", 32'(occ1), 32'd2);
      check("bp_full_ready", 32'(if1.inReady), 32'd0);
      check("bp_full_head", if1.outResult, 32'hA);
      set_in(1'b1, 32'hC, 32'h0, 5'd12, 1'b0, 1'b1);
      tick();
      check("bp_hold_ready", 32'(if1.inReady), 32'd0);
      check("bp_hold_head", if1.outResult, 32'hA);
      check("bp_hold_occ", 32'(occ1), 32'd2);
      if1.outReady = 1'b1;
      tick();
      check("bp_rel_ready", 32'(if1.inReady), 32'd1);
      check("bp_rel_head", if1.outResult, 32'hB);
      check("bp_rel_occ", 32'(occ1), 32'd1);
      tick();
      check("bp_c_head", if1.outResult, 32'hC);
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      tick();
      check("bp_empty_valid", 32'(if1.outValid), 32'd0);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Flush while FULL with a simultaneous input
      if1.outReady = 1'b0;
      set_in(1'b1, 32'h1, 32'h0, 5'd1, 1'b0, 1'b1);
      tick();
      set_in(1'b1, 32'h2, 32'h0, 5'd2, 1'b0, 1'b1);
      tick();
      check("fl_pre_occ", 32'(occ1), 32'd2);
      flush1 = 1'b1;
      set_in(1'b1, 32'hDEAD, 32'h0, 5'd7, 1'b0, 1'b1);
      tick();
      flush1 = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      check("fl_valid", 32'(if1.outValid), 32'd0);
      check("fl_occ", 32'(occ1), 32'd0);
      check("fl_ready", 32'(if1.inReady), 32'd1);
      check("fl_payload_kept", if1.outResult, 32'h1);
      if1.outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fl_no_dead", 32'(if1.outValid), 32'd0);
      end

      // Write-back select and register-0 suppression
      if1.outReady = 1'b0;
      set_in(1'b1, 32'h66, 32'h55, 5'd3, 1'b1, 1'b1);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      check("wb_data_mem", if1.outWriteData, 32'h55);
      check("wb_we", 32'(if1.outWriteEnable), 32'd1);
      if1.outReady = 1'b1;
      tick();
      if1.outReady = 1'b0;
      set_in(1'b1, 32'h66, 32'h55, 5'd0, 1'b1, 1'b1);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      check("wb_r0_we", 32'(if1.outWriteEnable), 32'd0);
      check("wb_r0_valid", 32'(if1.outValid), 32'd1);
      check("wb_r0_data", if1.outWriteData, 32'h55);
      if1.outReady = 1'b1;
      tick();
      if1.outReady = 1'b0;
      set_in(1'b1, 32'h66, 32'h55, 5'd3, 1'b0, 1'b1);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      check("wb_data_alu", if1.outWriteData, 32'h66);
      if1.outReady = 1'b1;
      tick();
      check("wb_drain_occ", 32'(occ1), 32'd0);

      // Reset mid-stream with two entries held
      if1.outReady = 1'b0;
      set_in(1'b1, 32'hA1, 32'h0, 5'd4, 1'b0, 1'b1);
      tick();
      set_in(1'b1, 32'hA2, 32'h0, 5'd5, 1'b0, 1'b1);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      check("mr_pre_occ", 32'(occ1), 32'd2);
      reset = 1'b1;
      #2;
      check("mr_valid", 32'(if1.outValid), 32'd0);
      check("mr_occ", 32'(occ1), 32'd0);
      check("mr_ready", 32'(if1.inReady), 32'd1);
      check("mr_result", if1.outResult, 32'h0);
      check("mr_rd", 32'(if1.outRd), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_in(1'b1, 32'h1234, 32'h0, 5'd6, 1'b0, 1'b1);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      check("mr_first_valid", 32'(if1.outValid), 32'd1);
      check("mr_first_result", if1.outResult, 32'h1234);
      if1.outReady = 1'b1;
      tick();
      check("mr_drain_occ", 32'(occ1), 32'd0);
      check("sb_final_empty", 32'(exp_q.size()), 32'd0);

      // SKID=0 instance: combinational ready and same-edge replace
      if0.outReady = 1'b0;
      if0.inValid  = 1'b1;
      if0.inResult = 32'h11;
      #1;
      check("s0_ready_empty", 32'(if0.inReady), 32'd1);
      @(posedge clk);
      #1;
      if0.inValid = 1'b0;
      #1;
      check("s0_hold_ready", 32'(if0.inReady), 32'd0);
      check("s0_hold_valid", 32'(if0.outValid), 32'd1);
      check("s0_hold_occ", 32'(occ0), 32'd1);
      check("s0_hold_head", if0.outResult, 32'h11);
      if0.outReady = 1'b1;
      if0.inValid  = 1'b1;
      if0.inResult = 32'h22;
      #1;
      check("s0_ready_comb", 32'(if0.inReady), 32'd1);
      @(posedge clk);
      #1;
      if0.inValid = 1'b0;
      #1;
      check("s0_replace_head", if0.outResult, 32'h22);
      check("s0_replace_occ", 32'(occ0), 32'd1);
      @(posedge clk);
      #1;
      check("s0_drain_occ", 32'(occ0), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
